// File: rtl/fp_to_bcd_sci_if.sv
// Request/result bundle between the FP datapath and the float-to-decimal converter.
interface fp_to_bcd_sci_if #(
  parameter int DIGITS = 7,
  parameter int EXP_W  = 7
);
  logic                  start;
  logic [31:0]           data;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;
  logic [EXP_W-1:0]      exp;
  logic                  is_zero;
  logic                  is_inf;
  logic                  is_nan;

  modport master (
    output start, data,
    input  busy, done, sign, bcd, exp, is_zero, is_inf, is_nan
  );

  modport slave (
    input  start, data,
    output busy, done, sign, bcd, exp, is_zero, is_inf, is_nan
  );
endinterface

// File: rtl/fp_to_bcd_sci.sv
// IEEE-754 single to signed scientific BCD: double-dabble the mantissa, scale by 2^e
// in a 9-digit BCD accumulator, normalise, round to DIGITS and report a biased exponent.
module fp_to_bcd_sci #(
  parameter int DIGITS   = 7,
  parameter int EXP_W    = 7,
  parameter int EXP_BIAS = 63,
  parameter int ROUND    = 1
) (
  input logic             clk,
  input logic             rstn,
  fp_to_bcd_sci_if.slave  bus
);

  localparam int BW  = 4 * DIGITS;
  localparam int NXT = 35 - BW;

  typedef enum logic [2:0] {IDLE, MANT, SCALE, NORM, RND, FIN} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, sign_q, sign_d;
  logic               zero_q, zero_d, inf_q, inf_d, nan_q, nan_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [35:0]        acc_q, acc_d;
  logic [23:0]        mant_q, mant_d;
  logic signed [8:0]  dexp_q, dexp_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [7:0]         emag_q, emag_d;
  logic               eneg_q, eneg_d, sgn_q, sgn_d, kz_q, kz_d, ki_q, ki_d, kn_q, kn_d;
  logic [7:0]         e_fld;
  logic [35:0]        t;
  logic [BW:0]        r;
  logic signed [15:0] exp_full;

  // One double-dabble step: BCD value times two plus the incoming bit.
  function automatic logic [35:0] bcd_dbl(input logic [35:0] a, input logic b);
    logic [35:0] v;
    v = a;
    for (int i = 0; i < 9; i++)
      if (a[4*i +: 4] >= 4'd5) v[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {v[34:0], b};
  endfunction

  // BCD halving; a bit crossing a nibble boundary is worth 5, not 8.
  function automatic logic [35:0] bcd_half(input logic [35:0] a);
    logic [35:0] v;
    v = {1'b0, a[35:1]};
    for (int i = 0; i < 9; i++)
      if (v[4*i +: 4] >= 4'd8) v[4*i +: 4] = v[4*i +: 4] - 4'd3;
    return v;
  endfunction

  // Round half-up on the first dropped digit; MSB of the result is the decimal carry out.
  function automatic logic [BW:0] bcd_round(input logic [BW-1:0] k, input logic [3:0] nxt);
    logic [BW-1:0] v;
    logic          c;
    v = k;
    c = (ROUND != 0) && (nxt >= 4'd5);
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) v[4*i +: 4] = 4'd0;
        else begin
          v[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, v};
  endfunction

  always_comb begin
    state_d = state_q;  busy_d = busy_q;  done_d = 1'b0;   sign_d = sign_q;
    zero_d  = zero_q;   inf_d  = inf_q;   nan_d  = nan_q;  bcd_d  = bcd_q;   exp_d = exp_q;
    acc_d   = acc_q;    mant_d = mant_q;  dexp_d = dexp_q; cnt_d  = cnt_q;
    emag_d  = emag_q;   eneg_d = eneg_q;  sgn_d  = sgn_q;
    kz_d    = kz_q;     ki_d   = ki_q;    kn_d   = kn_q;
    e_fld   = bus.data[30:23];
    t       = acc_q;
    r       = '0;
    exp_full = 16'(EXP_BIAS) + {{7{dexp_q[8]}}, dexp_q} + 16'sd8;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          sgn_d  = bus.data[31];
          kz_d   = (bus.data[30:0] == 31'd0);
          ki_d   = (e_fld == 8'hFF) && (bus.data[22:0] == 23'd0);
          kn_d   = (e_fld == 8'hFF) && (bus.data[22:0] != 23'd0);
          mant_d = {e_fld != 8'd0, bus.data[22:0]};
          acc_d  = '0;
          dexp_d = '0;
          cnt_d  = '0;
          // Denormals share the exponent of E=1 but without the hidden bit.
          eneg_d = (e_fld < 8'd150);
          if (e_fld == 8'd0)        emag_d = 8'd149;
          else if (e_fld < 8'd150)  emag_d = 8'd150 - e_fld;
          else                      emag_d = e_fld - 8'd150;
          busy_d  = 1'b1;
          state_d = (e_fld == 8'hFF || bus.data[30:0] == 31'd0) ? FIN : MANT;
        end
      end
      MANT: begin
        acc_d  = bcd_dbl(acc_q, mant_q[23]);
        mant_d = {mant_q[22:0], 1'b0};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          if (acc_d == '0)          state_d = FIN;
          else if (emag_q != 8'd0)  state_d = SCALE;
          else                      state_d = (acc_d[35:32] == 4'd0) ? NORM : RND;
        end
      end
      SCALE: begin
        // Pre-shift a digit so the doubling never overflows and halving keeps precision.
        if (!eneg_q) begin
          if (acc_q[35:32] >= 4'd5) begin
            t      = acc_q >> 4;
            dexp_d = dexp_q + 9'sd1;
          end
          acc_d = bcd_dbl(t, 1'b0);
        end else begin
          if (acc_q[35:32] == 4'd0) begin
            t      = acc_q << 4;
            dexp_d = dexp_q - 9'sd1;
          end
          acc_d = bcd_half(t);
        end
        emag_d = emag_q - 8'd1;
        if (emag_q == 8'd1) state_d = (acc_d[35:32] == 4'd0) ? NORM : RND;
      end
      NORM: begin
        acc_d  = acc_q << 4;
        dexp_d = dexp_q - 9'sd1;
        if (acc_d[35:32] != 4'd0) state_d = RND;
      end
      RND: begin
        r     = bcd_round(acc_q[35 -: BW], acc_q[NXT -: 4]);
        acc_d = '0;
        if (r[BW]) begin
          acc_d[35 -: BW] = BW'(1) << (BW - 4);
          dexp_d          = dexp_q + 9'sd1;
        end else begin
          acc_d[35 -: BW] = r[BW-1:0];
        end
        state_d = FIN;
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        sign_d  = sgn_q;
        zero_d  = kz_q;
        inf_d   = ki_q;
        nan_d   = kn_q;
        if (kz_q || ki_q || kn_q) begin
          bcd_d = '0;
          exp_d = EXP_W'(EXP_BIAS);
        end else begin
          bcd_d = acc_q[35 -: BW];
          exp_d = exp_full[EXP_W-1:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      bcd_q   <= '0;
      exp_q   <= EXP_W'(EXP_BIAS);
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      inf_q   <= inf_d;
      nan_q   <= nan_d;
      bcd_q   <= bcd_d;
      exp_q   <= exp_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    mant_q <= mant_d;
    dexp_q <= dexp_d;
    cnt_q  <= cnt_d;
    emag_q <= emag_d;
    eneg_q <= eneg_d;
    sgn_q  <= sgn_d;
    kz_q   <= kz_d;
    ki_q   <= ki_d;
    kn_q   <= kn_d;
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sign    = sign_q;
  assign bus.bcd     = bcd_q;
  assign bus.exp     = exp_q;
  assign bus.is_zero = zero_q;
  assign bus.is_inf  = inf_q;
  assign bus.is_nan  = nan_q;

endmodule

// File: tb/tb_fp_to_bcd_sci.sv
// Bench for fp_to_bcd_sci: three parameterisations run in lockstep, scoreboard against
// an integer-arithmetic decimal model.
module tb_fp_to_bcd_sci;

  logic clk;
  logic rstn;
  int   n_chk  = 0;
  int   n_fail = 0;

  fp_to_bcd_sci_if #(.DIGITS(7), .EXP_W(7)) if7  ();
  fp_to_bcd_sci_if #(.DIGITS(7), .EXP_W(7)) if7t ();
  fp_to_bcd_sci_if #(.DIGITS(3), .EXP_W(7)) if3  ();

  fp_to_bcd_sci #(.DIGITS(7), .EXP_W(7), .EXP_BIAS(63), .ROUND(1)) u7  (.clk(clk), .rstn(rstn), .bus(if7));
  fp_to_bcd_sci #(.DIGITS(7), .EXP_W(7), .EXP_BIAS(63), .ROUND(0)) u7t (.clk(clk), .rstn(rstn), .bus(if7t));
  fp_to_bcd_sci #(.DIGITS(3), .EXP_W(7), .EXP_BIAS(63), .ROUND(1)) u3  (.clk(clk), .rstn(rstn), .bus(if3));

  typedef struct {
    logic        sign, z, i, n;
    logic [27:0] bcd7, bcd7t;
    logic [11:0] bcd3;
    logic [6:0]  exp7, exp7t, exp3;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic longint p10(input int n);
    longint r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint v, input int nd);
    logic [31:0] b = '0;
    longint      w = v;
    for (int k = 0; k < nd; k++) begin
      b[4*k +: 4] = 4'(w % 10);
      w = w / 10;
    end
    return b;
  endfunction

  // Keep nd significant digits of the 9-digit value a * 10^dx, optionally round half-up.
  function automatic void rnd(input longint a, input int dx, input int nd, input bit rd,
                              output logic [31:0] b, output logic [6:0] ex);
    longint dv, keep;
    int     nxt, d2;
    dv   = p10(9 - nd);
    keep = a / dv;
    nxt  = int'((a / (dv / 10)) % 10);
    d2   = dx;
    if (rd && nxt >= 5) keep = keep + 1;
    if (keep == p10(nd)) begin
      keep = keep / 10;
      d2   = d2 + 1;
    end
    b  = to_bcd(keep, nd);
    ex = 7'(63 + d2 + 8);
  endfunction

  function automatic exp_t model(input logic [31:0] d);
    exp_t        x;
    int          ef, e, ae, dx, n;
    longint      a;
    logic [31:0] b;
    ef     = int'(d[30:23]);
    x.sign = d[31];
    x.z    = (d[30:0] == 31'd0);
    x.i    = (ef == 255) && (d[22:0] == 23'd0);
    x.n    = (ef == 255) && (d[22:0] != 23'd0);
    x.bcd7 = '0; x.bcd7t = '0; x.bcd3 = '0;
    x.exp7 = 7'd63; x.exp7t = 7'd63; x.exp3 = 7'd63;
    x.lat  = 2;
    if (x.z || x.i || x.n) return x;
    a = longint'(d[22:0]);
    if (ef != 0) a = a + 8388608;
    e  = (ef == 0) ? -149 : ef - 150;
    ae = (e < 0) ? -e : e;
    dx = 0;
    for (int k = 0; k < ae; k++) begin
      if (e > 0) begin
        if (a >= 500000000) begin a = a / 10; dx++; end
        a = a * 2;
      end else begin
        if (a < 100000000) begin a = a * 10; dx--; end
        a = a / 2;
      end
    end
    n = 0;
    while (a < 100000000) begin a = a * 10; dx--; n++; end
    x.lat = 27 + ae + n;
    rnd(a, dx, 7, 1'b1, b, x.exp7);  x.bcd7  = b[27:0];
    rnd(a, dx, 7, 1'b0, b, x.exp7t); x.bcd7t = b[27:0];
    rnd(a, dx, 3, 1'b1, b, x.exp3);  x.bcd3  = b[11:0];
    return x;
  endfunction

  task automatic set_in(input logic s, input logic [31:0] d);
    if7.start = s;  if7.data = d;
    if7t.start = s; if7t.data = d;
    if3.start = s;  if3.data = d;
  endtask

  // Monitor: every done pulse pops one expected record.
  always @(negedge clk) begin
    if (rstn && (if7.done || if7t.done || if3.done)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {31'd0, if7.done}, 32'd0);
      end else begin
        mx = sbq.pop_front();
        chk("done_sync", {30'd0, if7t.done, if3.done}, 32'd3);
        chk("sign",  {31'd0, if7.sign}, {31'd0, mx.sign});
        chk("flags", {29'd0, if7.is_zero, if7.is_inf, if7.is_nan}, {29'd0, mx.z, mx.i, mx.n});
        chk("bcd7",  32'(if7.bcd),  32'(mx.bcd7));
        chk("exp7",  32'(if7.exp),  32'(mx.exp7));
        chk("bcd7t", 32'(if7t.bcd), 32'(mx.bcd7t));
        chk("exp7t", 32'(if7t.exp), 32'(mx.exp7t));
        chk("bcd3",  32'(if3.bcd),  32'(mx.bcd3));
        chk("exp3",  32'(if3.exp),  32'(mx.exp3));
        chk("sign3", {31'd0, if3.sign}, {31'd0, mx.sign});
      end
    end
  end

  task automatic run(input logic [31:0] d, input bit poke);
    exp_t x;
    int   lat;
    x = model(d);
    sbq.push_back(x);
    @(negedge clk);
    set_in(1'b1, d);
    @(posedge clk);
    #1;
    lat = 1;
    chk("busy_after_accept", {31'd0, if7.busy}, 32'd1);
    while (!if7.done && lat < 400) begin
      if (poke && lat == 5) set_in(1'b1, 32'h40490FDB);
      else                  set_in(1'b0, $urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    set_in(1'b0, 32'd0);
    chk("latency", 32'(lat), 32'(x.lat));
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] dirs [14];
    dirs = '{32'h3F800000, 32'hC0200000, 32'h3F000000, 32'h44800000, 32'h4B7FFFFF,
             32'h4479E000, 32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
             32'hFF800000, 32'h00000001, 32'h7F7FFFFF, 32'h807FFFFF};
    rstn = 1'b0;
    set_in(1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, if7.busy}, 32'd0);
    chk("rst_done", {31'd0, if7.done}, 32'd0);
    chk("rst_bcd",  32'(if7.bcd), 32'd0);
    chk("rst_exp",  32'(if7.exp), 32'd63);
    chk("rst_flags", {28'd0, if7.sign, if7.is_zero, if7.is_inf, if7.is_nan}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run(32'h3F800000, 1'b1);
    chk("one_bcd", 32'(if7.bcd), 32'h1000000);
    chk("one_exp", 32'(if7.exp), 32'd63);
    run(32'h44800000, 1'b0);
    chk("k1024_bcd", 32'(if7.bcd), 32'h1024000);
    chk("k1024_exp", 32'(if7.exp), 32'd66);
    run(32'h4B7FFFFF, 1'b0);
    chk("max24_rnd",   32'(if7.bcd),  32'h1677722);
    chk("max24_trunc", 32'(if7t.bcd), 32'h1677721);
    chk("max24_exp",   32'(if7.exp),  32'd70);
    run(32'h4479E000, 1'b0);
    chk("carry_bcd", 32'(if3.bcd), 32'h100);
    chk("carry_exp", 32'(if3.exp), 32'd66);

    foreach (dirs[k]) run(dirs[k], (k % 4) == 1);
    for (int k = 0; k < 40; k++) run($urandom, (k % 8) == 3);

    // Abort a conversion with reset: no done may follow.
    @(negedge clk);
    set_in(1'b1, 32'h3F800000);
    @(posedge clk);
    #1;
    set_in(1'b0, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, if7.busy}, 32'd0);
    chk("abort_done", {31'd0, if7.done}, 32'd0);
    chk("abort_bcd",  32'(if7.bcd), 32'd0);
    chk("abort_exp",  32'(if7.exp), 32'd63);
    @(negedge clk);
    rstn = 1'b1;
    repeat (250) @(posedge clk);

    run(32'hC0200000, 1'b0);
    chk("neg_bcd", 32'(if7.bcd), 32'h2500000);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
